// File: rtl/signed_add_rr_arbiter.sv
// Round-robin shared signed adder: N_REQ requesters, one registered result stage.
// Optional macro SIGNED_ADD_RR_ARBITER_SATURATE_EN clamps the sum on overflow.
module signed_add_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [N_REQ-1:0]                             req_valid,
  input  logic [N_REQ*W-1:0]                           req_a,
  input  logic [N_REQ*W-1:0]                           req_b,
  output logic [N_REQ-1:0]                             req_ready,
  output logic                                         res_valid,
  input  logic                                         res_ready,
  output logic [W-1:0]                                 res_sum,
  output logic                                         res_overflow,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] res_id,
  output logic [CNT_W-1:0]                             ovf_count
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] ptr, grant_idx, ptr_nxt;
  logic            grant_found, free, transfer;
  logic [W-1:0]    op_a, op_b, sum_wrap, sum_final;
  logic            ovf;

  // Scan from the priority pointer, wrapping, and take the first valid requester.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!grant_found && req_valid[(int'(ptr) + k) % N_REQ]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'((int'(ptr) + k) % N_REQ);
      end
    end
  end

  assign res_valid = (state == FULL);
  assign free      = (state == EMPTY) || res_ready;
  assign transfer  = free && grant_found && !rst;

  always_comb begin
    req_ready = '0;
    if (transfer) req_ready[grant_idx] = 1'b1;
  end

  assign op_a     = req_a[grant_idx*W +: W];
  assign op_b     = req_b[grant_idx*W +: W];
  assign sum_wrap = op_a + op_b;
  assign ovf      = (op_a[W-1] == op_b[W-1]) && (sum_wrap[W-1] != op_a[W-1]);
  assign ptr_nxt  = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

`ifdef SIGNED_ADD_RR_ARBITER_SATURATE_EN
  // On overflow the true result lies beyond the range on the side of a's sign.
  assign sum_final = !ovf      ? sum_wrap :
                     op_a[W-1] ? {1'b1, {(W-1){1'b0}}} :
                                 {1'b0, {(W-1){1'b1}}};
`else
  assign sum_final = sum_wrap;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (transfer) state_nxt = FULL;
      FULL:    if (!transfer && res_ready) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_sum      <= '0;
      res_overflow <= 1'b0;
      res_id       <= '0;
      ptr          <= '0;
      ovf_count    <= '0;
    end else begin
      if (transfer) begin
        res_sum      <= sum_final;
        res_overflow <= ovf;
        res_id       <= grant_idx;
        ptr          <= ptr_nxt;
      end
      // Counted when the consumer takes an overflowing result; sticks at all-ones.
      if (res_valid && res_ready && res_overflow && (ovf_count != '1))
        ovf_count <= ovf_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_signed_add_rr_arbiter.sv
// Directed self-checking bench for signed_add_rr_arbiter (N_REQ=4, W=4, CNT_W=2).
module tb_signed_add_rr_arbiter;

  localparam int N_REQ = 4;
  localparam int W     = 4;
  localparam int CNT_W = 2;

`ifdef SIGNED_ADD_RR_ARBITER_SATURATE_EN
  localparam logic [3:0] S_4P7 = 4'b0111, S_M8M1 = 4'b1000, S_7P1 = 4'b0111, S_M3M6 = 4'b1000;
`else
  localparam logic [3:0] S_4P7 = 4'b1011, S_M8M1 = 4'b0111, S_7P1 = 4'b1000, S_M3M6 = 4'b0111;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_a, req_b;
  logic [N_REQ-1:0]   req_ready;
  logic               res_valid, res_ready, res_overflow;
  logic [W-1:0]       res_sum;
  logic [1:0]         res_id;
  logic [CNT_W-1:0]   ovf_count;

  int checks = 0;
  int errors = 0;

  // Directed vectors: id, a, b, expected sum, overflow, ovf_count after the edge.
  int         tv_id [7] = '{0, 1, 2, 3, 0, 1, 2};
  logic [3:0] tv_a  [7] = '{4'd1, 4'd4, 4'b1100, 4'b1000, 4'd7, 4'b1000, 4'd4};
  logic [3:0] tv_b  [7] = '{4'd2, 4'd7, 4'b1100, 4'b1111, 4'd1, 4'd7, 4'b1100};
  logic [3:0] tv_s  [7] = '{4'd3, S_4P7, 4'b1000, S_M8M1, S_7P1, 4'b1111, 4'd0};
  logic       tv_o  [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [1:0] tv_c  [7] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};

  signed_add_rr_arbiter #(.N_REQ(N_REQ), .W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_overflow(res_overflow), .res_id(res_id),
    .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Present one pair on requester id only.
  task automatic applyStimulus(input int id, input logic [3:0] a, input logic [3:0] b);
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_valid[id] = 1'b1;
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; res_ready = 1'b1;
    req_valid = '1; req_a = '0; req_b = '0;
    #2;
    checkOutput("rst_valid",  32'(res_valid), 0);
    checkOutput("rst_sum",    32'(res_sum), 0);
    checkOutput("rst_ovf",    32'(res_overflow), 0);
    checkOutput("rst_id",     32'(res_id), 0);
    checkOutput("rst_cnt",    32'(ovf_count), 0);
    checkOutput("rst_ready",  32'(req_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;

    // Back-to-back single requests, covering the overflow boundaries.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(tv_id[i], tv_a[i], tv_b[i]);
      #1;
      checkOutput($sformatf("tv%0d_ready", i), 32'(req_ready), 32'(1 << tv_id[i]));
      cycle();
      checkOutput($sformatf("tv%0d_valid", i), 32'(res_valid), 1);
      checkOutput($sformatf("tv%0d_sum", i),   32'(res_sum), 32'(tv_s[i]));
      checkOutput($sformatf("tv%0d_ovf", i),   32'(res_overflow), 32'(tv_o[i]));
      checkOutput($sformatf("tv%0d_id", i),    32'(res_id), 32'(tv_id[i]));
      checkOutput($sformatf("tv%0d_cnt", i),   32'(ovf_count), 32'(tv_c[i]));
    end
    req_valid = '0;
    cycle();
    checkOutput("idle_valid", 32'(res_valid), 0);
    checkOutput("idle_cnt",   32'(ovf_count), 3);
    checkOutput("idle_sum_hold", 32'(res_sum), 0);

    // Hold a result, then assert reset between edges.
    applyStimulus(3, 4'd7, 4'd1);
    cycle();
    checkOutput("pre_rst_valid", 32'(res_valid), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_valid", 32'(res_valid), 0);
    checkOutput("arst_cnt",   32'(ovf_count), 0);
    checkOutput("arst_sum",   32'(res_sum), 0);
    checkOutput("arst_ready", 32'(req_ready), 0);
    #1 rst = 1'b0;

    // All requesters valid: grants rotate starting from requester 0.
    req_valid = '1;
    for (int i = 0; i < N_REQ; i++) begin
      req_a[i*W +: W] = 4'(i);
      req_b[i*W +: W] = 4'd1;
    end
    #1;
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("rr%0d_ready", k), 32'(req_ready), 32'(1 << (k % 4)));
      cycle();
      checkOutput($sformatf("rr%0d_id", k),  32'(res_id), 32'(k % 4));
      checkOutput($sformatf("rr%0d_sum", k), 32'(res_sum), 32'((k % 4) + 1));
    end
    checkOutput("rr_cnt", 32'(ovf_count), 0);

    // Backpressure on -3 + -6.
    applyStimulus(0, 4'b1101, 4'b1010);
    cycle();
    checkOutput("bp_load_sum", 32'(res_sum), 32'(S_M3M6));
    res_ready = 1'b0;
    applyStimulus(1, 4'd1, 4'd1);
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput($sformatf("bp%0d_ready", k), 32'(req_ready), 0);
      cycle();
      checkOutput($sformatf("bp%0d_valid", k), 32'(res_valid), 1);
      checkOutput($sformatf("bp%0d_sum", k),   32'(res_sum), 32'(S_M3M6));
      checkOutput($sformatf("bp%0d_ovf", k),   32'(res_overflow), 1);
      checkOutput($sformatf("bp%0d_id", k),    32'(res_id), 0);
      checkOutput($sformatf("bp%0d_cnt", k),   32'(ovf_count), 0);
    end
    res_ready = 1'b1;
    #1;
    checkOutput("drain_ready", 32'(req_ready), 32'b0010);
    cycle();
    checkOutput("drain_sum", 32'(res_sum), 2);
    checkOutput("drain_id",  32'(res_id), 1);
    checkOutput("drain_cnt", 32'(ovf_count), 1);
    req_valid = '0;
    cycle();
    checkOutput("drain_idle_valid", 32'(res_valid), 0);
    checkOutput("drain_idle_cnt",   32'(ovf_count), 1);

    // Five overflowing results drained; counter sticks at 3.
    applyStimulus(0, 4'd7, 4'd1);
    for (int k = 0; k < 5; k++) begin
      cycle();
      checkOutput($sformatf("sat%0d_sum", k), 32'(res_sum), 32'(S_7P1));
      checkOutput($sformatf("sat%0d_cnt", k), 32'(ovf_count), (k + 1 > 3) ? 3 : k + 1);
    end
    req_valid = '0;
    cycle();
    checkOutput("sat_final_cnt",   32'(ovf_count), 3);
    checkOutput("sat_final_valid", 32'(res_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
